// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: one outstanding 32-bit read per accepted PC, result held for decode.
// Optional misaligned-PC trap enabled by defining YSYX_22040895_IFU_MISALIGN_CHECK_EN.
module ysyx_22040895_ifu #(
   parameter int unsigned          ADDR_W   = 64,
   parameter int unsigned          INST_W   = 32,
   parameter logic [INST_W-1:0]    NOP_INST = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ce_i,
   output logic              pc_ready_o,
   input  logic              flush_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [INST_W-1:0] imem_rsp_data_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic                drop_q, drop_d;
   logic                pc_accept;

`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
   logic                misalign_q, misalign_d;
   logic                pc_misaligned;

   assign pc_misaligned = (pc_i[1:0] != 2'b00);
   assign misalign_o    = misalign_q;
`else
   assign misalign_o    = 1'b0;
`endif

   assign pc_accept = (state_q == StIdle) && ce_i && !flush_i;

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      inst_d           = inst_q;
      drop_d           = drop_q;
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
      misalign_d       = misalign_q;
`endif
      pc_ready_o       = 1'b0;
      imem_req_valid_o = 1'b0;
      inst_valid_o     = 1'b0;

      unique case (state_q)
         StIdle: begin
            pc_ready_o = pc_accept;
            if (pc_accept) begin
               pc_d   = pc_i;
               drop_d = 1'b0;
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
               if (pc_misaligned) begin
                  inst_d     = NOP_INST;
                  misalign_d = 1'b1;
                  state_d    = StHold;
               end else begin
                  state_d = StReq;
               end
`else
               state_d = StReq;
`endif
            end
         end

         // The request is never withdrawn once raised; a flush only marks its data for discard.
         StReq: begin
            imem_req_valid_o = 1'b1;
            if (flush_i) begin
               drop_d = 1'b1;
            end
            if (imem_req_ready_i) begin
               state_d = StWait;
            end
         end

         StWait: begin
            if (imem_rsp_valid_i) begin
               if (drop_q || flush_i) begin
                  state_d = StIdle;
               end else begin
                  inst_d  = imem_rsp_data_i;
                  state_d = StHold;
               end
            end else if (flush_i) begin
               drop_d = 1'b1;
            end
         end

         StHold: begin
            inst_valid_o = 1'b1;
            if (flush_i || inst_ready_i) begin
               state_d = StIdle;
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
               misalign_d = 1'b0;
`endif
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pc_q       <= '0;
         inst_q     <= NOP_INST;
         drop_q     <= 1'b0;
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         drop_q     <= drop_d;
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Address and PC outputs come straight from the held PC, so both read 0 out of reset.
   assign imem_addr_o = pc_q;
   assign inst_pc_o   = pc_q;
   assign inst_o      = inst_q;

endmodule
